// File: rtl/bist_scan_controller.sv
// Top-level BIST-per-scan sequencer: runs N_PATTERNS shift/capture patterns,
// flushes the last response through the MISR and checks the signature.
module bist_scan_controller #(
  parameter int CHAIN_LEN  = 26,
  parameter int N_PATTERNS = 100,
  parameter int SIG_W      = 26,
  parameter logic [SIG_W-1:0] GOLDEN = {SIG_W{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [SIG_W-1:0] signature,
  output logic             reset_internal,
  output logic             control_state,
  output logic             control_misr,
  output logic             scan_en,
  output logic             test_mode,
  output logic             done,
  output logic             pass
);

  localparam int SCW = $clog2(CHAIN_LEN + 1);
  localparam int PCW = $clog2(N_PATTERNS + 1);
  localparam logic [SCW-1:0] SHIFT_LAST = SCW'(CHAIN_LEN - 1);
  localparam logic [PCW-1:0] PAT_LAST   = PCW'(N_PATTERNS - 1);
  localparam logic [SCW-1:0] SC_ONE     = SCW'(32'd1);
  localparam logic [PCW-1:0] PC_ONE     = PCW'(32'd1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    FLUSH   = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state_r;
  logic [SCW-1:0]   shift_cnt_r;
  logic [PCW-1:0]   pat_cnt_r;
  logic             done_r;
  logic             pass_r;

  // Sequencer state, shift/pattern counters and the sticky result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      shift_cnt_r <= {SCW{1'b0}};
      pat_cnt_r   <= {PCW{1'b0}};
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          // Result flags drop as INIT is entered so a rerun never shows stale done/pass.
          if (start) begin
            state_r     <= INIT;
            shift_cnt_r <= {SCW{1'b0}};
            pat_cnt_r   <= {PCW{1'b0}};
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
          end
        end
        INIT: begin
          shift_cnt_r <= {SCW{1'b0}};
          pat_cnt_r   <= {PCW{1'b0}};
          done_r      <= 1'b0;
          pass_r      <= 1'b0;
          state_r     <= SHIFT;
        end
        SHIFT: begin
          if (shift_cnt_r == SHIFT_LAST) begin
            shift_cnt_r <= {SCW{1'b0}};
            state_r     <= CAPTURE;
          end else begin
            shift_cnt_r <= shift_cnt_r + SC_ONE;
          end
        end
        CAPTURE: begin
          pat_cnt_r <= pat_cnt_r + PC_ONE;
          state_r   <= (pat_cnt_r == PAT_LAST) ? FLUSH : SHIFT;
        end
        FLUSH: begin
          if (shift_cnt_r == SHIFT_LAST) begin
            shift_cnt_r <= {SCW{1'b0}};
            state_r     <= CHECK;
          end else begin
            shift_cnt_r <= shift_cnt_r + SC_ONE;
          end
        end
        CHECK: begin
          pass_r  <= (signature == GOLDEN);
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Control decode from the registered state; reset forces the LFSR/MISR reinit.
  always_comb begin
    reset_internal = 1'b0;
    control_state  = 1'b0;
    control_misr   = 1'b0;
    scan_en        = 1'b0;
    test_mode      = 1'b0;
    done           = 1'b0;
    pass           = 1'b0;
    if (reset) begin
      reset_internal = 1'b1;
    end else begin
      done = done_r;
      pass = pass_r;
      case (state_r)
        INIT: begin
          reset_internal = 1'b1;
          test_mode      = 1'b1;
        end
        SHIFT: begin
          // The first pattern's unload is power-up garbage, so keep it out of the MISR.
          scan_en       = 1'b1;
          control_state = 1'b1;
          control_misr  = (pat_cnt_r != {PCW{1'b0}});
          test_mode     = 1'b1;
        end
        CAPTURE, CHECK: test_mode = 1'b1;
        FLUSH: begin
          scan_en      = 1'b1;
          control_misr = 1'b1;
          test_mode    = 1'b1;
        end
        default: test_mode = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/bist_scan_controller.md
Name: bist_scan_controller

Overview:
- Top-level sequencer for the BIST-per-scan architecture.
- Drives the scan-in stimulus LFSR (advance enable, internal reset), the scan-chain scan enable and the response MISR compression enable.
- Runs a fixed number of shift/capture patterns, then unloads the last response, compares the MISR signature against a golden value, and reports done/pass.

Parameters:
- CHAIN_LEN, 26: scan-chain length in flops; shift cycles per pattern. Must be >=1.
- N_PATTERNS, 100: number of capture patterns per test run. Must be >=1.
- SIG_W, 26: MISR signature width.
- GOLDEN, 0 (SIG_W bits): expected final signature.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; forces IDLE
- start  in  1  level-sampled request to begin a test run
- signature  in  SIG_W  current MISR contents
- reset_internal  out  1  reinitialise LFSR and MISR
- control_state  out  1  advance enable for the stimulus LFSR
- control_misr  out  1  compression enable for the MISR
- scan_en  out  1  1 = chain shifts, 0 = functional capture
- test_mode  out  1  high while a run is in progress
- done  out  1  run complete; held until the next run starts or reset
- pass  out  1  valid when done=1: signature matched GOLDEN

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Registered state:
  - FSM state.
  - shift_cnt: $clog2(CHAIN_LEN+1) bits.
  - pat_cnt: $clog2(N_PATTERNS+1) bits.
  - done and pass flags.
- Outputs are decoded combinationally from the registered state. They take effect in the same cycle the state is entered.
- Reset:
  - state=IDLE, counters=0, done=0, pass=0.
  - All outputs are 0 except reset_internal=1 while reset is high.
  - Reset mid-run aborts immediately; no partial done/pass.
- IDLE:
  - All outputs 0.
  - start=1 -> INIT.
- INIT (1 cycle):
  - reset_internal=1, test_mode=1.
  - Clears shift_cnt, pat_cnt, done, pass.
  - -> SHIFT.
- SHIFT (CHAIN_LEN cycles):
  - scan_en=1, control_state=1, test_mode=1.
  - control_misr=1 only when pat_cnt>0, so the unknown power-up chain contents are not compressed.
  - shift_cnt counts 0..CHAIN_LEN-1. On the last count it clears and the FSM goes to CAPTURE.
- CAPTURE (1 cycle):
  - scan_en=0, control_state=0, control_misr=0, test_mode=1.
  - pat_cnt increments.
  - If pat_cnt was N_PATTERNS-1 -> FLUSH, else -> SHIFT.
- FLUSH (CHAIN_LEN cycles):
  - scan_en=1, control_misr=1, control_state=0 (LFSR frozen), test_mode=1.
  - Unloads the final response. Then -> CHECK.
- CHECK (1 cycle):
  - test_mode=1, scan_en=0, control_misr=0.
  - pass <= (signature==GOLDEN), done <= 1.
  - -> DONE.
- DONE:
  - All control outputs 0; done and pass held.
  - start=1 -> INIT (rerun; done/pass clear in INIT).
  - DONE never returns to IDLE except via reset.
- start is ignored in every state other than IDLE and DONE. Holding start high in DONE restarts back-to-back runs.
- Run length from the edge sampling start to done=1: 1 + N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles.
- Per run:
  - control_state is high for exactly N_PATTERNS*CHAIN_LEN cycles.
  - control_misr is high for exactly N_PATTERNS*CHAIN_LEN cycles: (N_PATTERNS-1)*CHAIN_LEN during SHIFT plus CHAIN_LEN during FLUSH.
- Boundary cases:
  - N_PATTERNS=1: a single SHIFT with control_misr=0, CAPTURE, FLUSH.
  - CHAIN_LEN=1: SHIFT and FLUSH each last 1 cycle.
- Counters never wrap. Widths are sized so that N_PATTERNS and CHAIN_LEN are representable.

Test Plan:
- CHAIN_LEN=4, N_PATTERNS=2, start pulsed at edge 0 -> state sequence after each edge: INIT(e0), SHIFT(e1–e4), CAPTURE(e5), SHIFT(e6–e9), CAPTURE(e10), FLUSH(e11–e14), CHECK(e15), DONE(e16); done=1 after e16. Counts: control_state high 8 cycles, control_misr high 8 cycles, scan_en low only in CAPTURE/CHECK.
- Same config, signature held at GOLDEN during CHECK -> pass=1, done=1. Signature=GOLDEN^1 -> pass=0, done=1.
- Reset asserted in the 3rd SHIFT cycle -> next cycle IDLE with outputs 0 and reset_internal=1 while reset is high. A new start gives a full 17-cycle run.
- start toggled high during SHIFT/CAPTURE/FLUSH -> no effect on sequence or cycle count.
- In DONE with pass=1, start=1 -> INIT clears done and pass, reset_internal pulses for 1 cycle, and the second run completes with identical timing.
- Default config (26, 100), start once -> done after 1+100*27+26+1=2728 cycles; control_state high exactly 2600 cycles.
